// File: rtl/sfx_player_if.sv
// Bundle of the sfx_player pins: game-event triggers, volume, sample ROM port and status.
// The controller side uses the slave modport. The game logic and ROM side uses the master modport.
interface sfx_player_if #(
    parameter int SAMPLE_W = 7,
    parameter int ADDR_W   = 8,
    parameter int NUM_SFX  = 4,
    parameter int ID_W     = 2
);

    logic [NUM_SFX-1:0]  trigger;
    logic [1:0]          volume;
    logic [ADDR_W-1:0]   mem_addr;
    logic [SAMPLE_W-1:0] mem_data;
    logic                sound;
    logic                busy;
    logic [ID_W-1:0]     active_id;
    logic                done;

    modport master (
        output trigger,
        output volume,
        output mem_data,
        input  mem_addr,
        input  sound,
        input  busy,
        input  active_id,
        input  done
    );

    modport slave (
        input  trigger,
        input  volume,
        input  mem_data,
        output mem_addr,
        output sound,
        output busy,
        output active_id,
        output done
    );

endinterface

// File: rtl/sfx_player.sv
// Multi-effect sound player.
// It walks a per-effect window of a shared sample ROM at a fixed sample rate.
// Each effect can optionally repeat a tail loop segment.
// The current sample drives a volume-scaled PWM speaker output.
module sfx_player #(
    parameter int SAMPLE_W = 7,
    parameter int ADDR_W   = 8,
    parameter int NUM_SFX  = 4,
    parameter int ID_W     = 2,
    parameter int RATE_DIV = 9766,
    parameter int RATE_W   = 14,
    parameter logic [NUM_SFX*ADDR_W-1:0] SFX_BASE = '0,
    parameter logic [NUM_SFX*ADDR_W-1:0] SFX_LAST = '0,
    parameter logic [NUM_SFX*ADDR_W-1:0] SFX_LOOP = '0,
    parameter logic [NUM_SFX*8-1:0]      SFX_REP  = '0
) (
    input  logic         clk,
    input  logic         rst,
    sfx_player_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [RATE_W-1:0]   prescaler, prescaler_n;
    logic [ADDR_W-1:0]   offset, offset_n;
    logic [7:0]          reps_left, reps_left_n;
    logic [SAMPLE_W-1:0] duty, duty_n;
    logic [SAMPLE_W-1:0] pwm_cnt;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_n;
    logic [ID_W-1:0]     active_id_q, active_id_n;
    logic                done_q, done_n;
    logic                sound_q;

    logic                tick;
    logic                any_trigger;
    logic [ID_W-1:0]     winner;
    logic                accept;

    logic [ADDR_W-1:0]   cur_base, cur_last, cur_loop;
    logic [ADDR_W-1:0]   win_base;
    logic [7:0]          win_rep;

    // Look up an ADDR_W-wide entry of a packed per-effect table.
    // An index beyond NUM_SFX returns zero.
    function automatic logic [ADDR_W-1:0] addr_entry(
        input logic [NUM_SFX*ADDR_W-1:0] tbl,
        input logic [ID_W-1:0]           idx
    );
        logic [ADDR_W-1:0] result;
        result = '0;
        for (int i = 0; i < NUM_SFX; i++) begin
            if (idx == ID_W'(i)) begin
                result = tbl[i*ADDR_W +: ADDR_W];
            end
        end
        return result;
    endfunction

    // Look up an 8-bit repeat count of a packed per-effect table.
    function automatic logic [7:0] rep_entry(
        input logic [NUM_SFX*8-1:0] tbl,
        input logic [ID_W-1:0]      idx
    );
        logic [7:0] result;
        result = '0;
        for (int i = 0; i < NUM_SFX; i++) begin
            if (idx == ID_W'(i)) begin
                result = tbl[i*8 +: 8];
            end
        end
        return result;
    endfunction

    assign tick = (prescaler == RATE_W'(RATE_DIV - 1));

    // Fixed-priority arbiter: the lowest-numbered pending trigger wins.
    always_comb begin
        winner      = '0;
        any_trigger = 1'b0;
        for (int i = NUM_SFX - 1; i >= 0; i--) begin
            if (bus.trigger[i]) begin
                winner      = ID_W'(i);
                any_trigger = 1'b1;
            end
        end
    end

    // An idle player takes any trigger.
    // A playing one restarts only for the same or a higher priority effect.
    assign accept = any_trigger && ((state == IDLE) || (winner <= active_id_q));

    assign cur_base = addr_entry(SFX_BASE, active_id_q);
    assign cur_last = addr_entry(SFX_LAST, active_id_q);
    assign cur_loop = addr_entry(SFX_LOOP, active_id_q);
    assign win_base = addr_entry(SFX_BASE, winner);
    assign win_rep  = rep_entry(SFX_REP, winner);

    // Next-state and datapath decisions.
    // A fresh trigger overrides whatever the sample tick would have done.
    always_comb begin
        state_n     = state;
        prescaler_n = tick ? '0 : prescaler + 1'b1;
        offset_n    = offset;
        reps_left_n = reps_left;
        duty_n      = duty;
        mem_addr_n  = mem_addr_q;
        active_id_n = active_id_q;
        done_n      = 1'b0;

        if (accept) begin
            active_id_n = winner;
            offset_n    = '0;
            mem_addr_n  = win_base;
            reps_left_n = win_rep;
            prescaler_n = '0;
            state_n     = PLAY;
        end else begin
            case (state)
                PLAY: begin
                    if (tick) begin
                        duty_n = bus.mem_data;
                        if (offset < cur_last) begin
                            offset_n = offset + 1'b1;
                        end else if (reps_left != 8'd0) begin
                            offset_n    = cur_loop;
                            reps_left_n = reps_left - 8'd1;
                        end else begin
                            state_n = TAIL;
                        end
                        mem_addr_n = cur_base + offset_n;
                    end
                end
                TAIL: begin
                    if (tick) begin
                        duty_n  = '0;
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Playback state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            prescaler   <= '0;
            offset      <= '0;
            reps_left   <= '0;
            duty        <= '0;
            mem_addr_q  <= '0;
            active_id_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_n;
            prescaler   <= prescaler_n;
            offset      <= offset_n;
            reps_left   <= reps_left_n;
            duty        <= duty_n;
            mem_addr_q  <= mem_addr_n;
            active_id_q <= active_id_n;
            done_q      <= done_n;
        end
    end

    // Free-running PWM carrier.
    // The output compares the carrier against the volume-attenuated duty.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
            sound_q <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            sound_q <= (pwm_cnt < (duty >> bus.volume));
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.sound     = sound_q;
    assign bus.busy      = (state != IDLE);
    assign bus.active_id = active_id_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_sfx_player.sv
// Testbench for sfx_player.
// A list-based playback model predicts the outputs after every clock edge.
// A monitor pops each prediction and compares it against the DUT.
module tb_sfx_player;

    localparam int SAMPLE_W = 7;
    localparam int ADDR_W   = 8;
    localparam int NUM_SFX  = 4;
    localparam int ID_W     = 2;
    localparam int RATE_DIV = 4;
    localparam int RATE_W   = 3;

    // Effect table as seen by the reference model.
    int base_t [NUM_SFX] = '{10, 40, 100, 250};
    int last_t [NUM_SFX] = '{3, 5, 6, 9};
    int loop_t [NUM_SFX] = '{0, 4, 2, 0};
    int rep_t  [NUM_SFX] = '{0, 2, 1, 0};

    logic clk = 1'b0;
    logic rst;

    sfx_player_if #(
        .SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W), .NUM_SFX(NUM_SFX), .ID_W(ID_W)
    ) bus ();

    sfx_player #(
        .SAMPLE_W(SAMPLE_W),
        .ADDR_W  (ADDR_W),
        .NUM_SFX (NUM_SFX),
        .ID_W    (ID_W),
        .RATE_DIV(RATE_DIV),
        .RATE_W  (RATE_W),
        .SFX_BASE({8'd250, 8'd100, 8'd40, 8'd10}),
        .SFX_LAST({8'd9, 8'd6, 8'd5, 8'd3}),
        .SFX_LOOP({8'd0, 8'd2, 8'd4, 8'd0}),
        .SFX_REP ({8'd0, 8'd1, 8'd2, 8'd0})
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [SAMPLE_W-1:0] rom [256];
    assign bus.mem_data = rom[bus.mem_addr];

    typedef struct {
        logic       busy;
        logic       done;
        logic       sound;
        logic [1:0] id;
        logic [7:0] addr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model state: the list of ROM addresses the current effect plays, and progress through it.
    int m_list[$];
    int m_idx   = 0;
    int m_busy  = 0;
    int m_done  = 0;
    int m_sound = 0;
    int m_id    = 0;
    int m_addr  = 0;
    int m_duty  = 0;
    int m_pwm   = 0;
    int m_pre   = 0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, want);
        end
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic modelStep(input logic [3:0] trig, input logic [1:0] vol, input logic r);
        int  w;
        bit  tick;
        bit  snd;
        if (r) begin
            m_busy = 0; m_done = 0; m_sound = 0; m_id = 0; m_addr = 0;
            m_duty = 0; m_pwm = 0; m_pre = 0; m_idx = 0;
            m_list.delete();
        end else begin
            snd   = (m_pwm < (m_duty >> vol));
            m_pwm = (m_pwm + 1) % (1 << SAMPLE_W);
            tick  = (m_pre == RATE_DIV - 1);
            m_pre = tick ? 0 : m_pre + 1;
            m_done = 0;
            w = -1;
            for (int i = NUM_SFX - 1; i >= 0; i--) begin
                if (trig[i]) w = i;
            end
            if (w >= 0 && (m_busy == 0 || w <= m_id)) begin
                m_id = w;
                m_list.delete();
                for (int off = 0; off <= last_t[w]; off++) begin
                    m_list.push_back((base_t[w] + off) % 256);
                end
                for (int rr = 0; rr < rep_t[w]; rr++) begin
                    for (int off = loop_t[w]; off <= last_t[w]; off++) begin
                        m_list.push_back((base_t[w] + off) % 256);
                    end
                end
                m_idx  = 0;
                m_addr = m_list[0];
                m_busy = 1;
                m_pre  = 0;
            end else if (m_busy != 0 && tick) begin
                if (m_idx < m_list.size()) begin
                    m_duty = int'(rom[m_list[m_idx]]);
                    m_idx++;
                    if (m_idx < m_list.size()) m_addr = m_list[m_idx];
                end else begin
                    m_duty = 0;
                    m_busy = 0;
                    m_done = 1;
                end
            end
            m_sound = snd;
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic applyStimulus(input logic [3:0] trig, input logic [1:0] vol, input logic r);
        exp_t e;
        @(negedge clk);
        bus.trigger = trig;
        bus.volume  = vol;
        rst         = r;
        modelStep(trig, vol, r);
        e.busy  = (m_busy != 0);
        e.done  = (m_done != 0);
        e.sound = (m_sound != 0);
        e.id    = 2'(m_id);
        e.addr  = 8'(m_addr);
        exp_q.push_back(e);
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(4'b0000, 2'($urandom_range(0, 3)), 1'b0);
        end
    endtask

    // Start one effect from idle and check its total busy time and its single done pulse.
    task automatic runAndMeasure(input logic [3:0] trig, input int id);
        int want;
        int busy_cnt;
        int dones;
        want = ((last_t[id] + 1) + rep_t[id] * (last_t[id] - loop_t[id] + 1) + 1) * RATE_DIV;
        busy_cnt = 0;
        dones    = 0;
        applyStimulus(trig, 2'd0, 1'b0);
        for (int k = 0; k < want + 10; k++) begin
            applyStimulus(4'b0000, 2'($urandom_range(0, 3)), 1'b0);
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) dones++;
        end
        checkOutput("busy_duration", 32'(busy_cnt), 32'(want));
        checkOutput("done_pulses", 32'(dones), 32'd1);
    endtask

    // Monitor: after every edge, compare the DUT against the oldest prediction.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                checkOutput("busy",      32'(bus.busy),      32'(mon_e.busy));
                checkOutput("done",      32'(bus.done),      32'(mon_e.done));
                checkOutput("sound",     32'(bus.sound),     32'(mon_e.sound));
                checkOutput("active_id", 32'(bus.active_id), 32'(mon_e.id));
                checkOutput("mem_addr",  32'(bus.mem_addr),  32'(mon_e.addr));
            end
        end
    end

    initial begin
        logic [3:0] trig;
        for (int a = 0; a < 256; a++) rom[a] = 7'($urandom);
        rom[10] = 7'd64;
        bus.trigger = '0;
        bus.volume  = '0;
        rst         = 1'b1;

        applyStimulus(4'b0000, 2'd0, 1'b1);
        applyStimulus(4'b0000, 2'd0, 1'b1);
        applyStimulus(4'b0000, 2'd0, 1'b1);
        idleCycles(3);

        runAndMeasure(4'b0001, 0);
        runAndMeasure(4'b0010, 1);
        runAndMeasure(4'b1000, 3);

        $display("[TB] priority: effect 2, lower-priority 3 ignored, then preempted by 1");
        applyStimulus(4'b0100, 2'd0, 1'b0);
        idleCycles(10);
        applyStimulus(4'b1000, 2'd1, 1'b0);
        idleCycles(5);
        applyStimulus(4'b0010, 2'd0, 1'b0);
        idleCycles(50);

        applyStimulus(4'b0110, 2'd0, 1'b0);
        idleCycles(50);

        $display("[TB] reset during playback");
        applyStimulus(4'b0100, 2'd0, 1'b0);
        idleCycles(9);
        applyStimulus(4'b0001, 2'd0, 1'b1);
        idleCycles(10);

        $display("[TB] retrigger on the final tick");
        applyStimulus(4'b0001, 2'd0, 1'b0);
        idleCycles(19);
        applyStimulus(4'b0001, 2'd2, 1'b0);
        idleCycles(30);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 2500; k++) begin
            trig = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'b0000;
            applyStimulus(trig, 2'($urandom_range(0, 3)), ($urandom_range(0, 499) == 0));
        end
        idleCycles(3);

        @(posedge clk);
        #2;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sfx_player.md
# sfx_player

Multi-effect sound player replacing the single-effect audio controller. It holds a parameter table of NUM_SFX effects stored in a shared sample ROM and accepts one-cycle trigger pulses, arbitrating between them by fixed priority. Each effect can repeat a tail loop segment a configurable number of times, and playback volume is programmable. The selected sample drives a registered PWM output to the speaker pin, fed by the game-logic event pulses.

## Interface

- SAMPLE_W, 7: sample width in bits; also PWM counter width.
- ADDR_W, 8: sample ROM address width.
- NUM_SFX, 4: number of effects.
- ID_W, 2: width of effect index; ≥ clog2(NUM_SFX).
- RATE_DIV, 9766: clk cycles per sample tick; must be ≥ 2.
- RATE_W, 14: prescaler width; 2^RATE_W > RATE_DIV.
- SFX_BASE, 0: packed NUM_SFX×ADDR_W ROM base addresses; entry i at [i*ADDR_W +: ADDR_W].
- SFX_LAST, 0: packed NUM_SFX×ADDR_W offset of the last sample. Length is LAST+1.
- SFX_LOOP, 0: packed NUM_SFX×ADDR_W loop-start offset; must be ≤ LAST.
- SFX_REP, 0: packed NUM_SFX×8 extra passes over [LOOP..LAST]; 0 means no loop.

Ports:

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- trigger  in  NUM_SFX  one-cycle start pulses. Bit i starts effect i.
- volume  in  2  attenuation; effective duty = duty >> volume.
- mem_addr  out  ADDR_W  registered ROM address.
- mem_data  in  SAMPLE_W  combinational ROM data for mem_addr.
- sound  out  1  registered PWM speaker output.
- busy  out  1  high when state ≠ IDLE.
- active_id  out  ID_W  index of the effect currently playing.
- done  out  1  one-cycle pulse at natural end of playback.

## Operation

- States: IDLE, PLAY, TAIL.
- Registers: prescaler, offset (ADDR_W), reps_left (8), duty (SAMPLE_W), pwm_cnt (SAMPLE_W).
- Arbitration: the lowest set trigger bit wins.
  - Accepted in IDLE.
  - In PLAY/TAIL, accepted only if its index is ≤ active_id (same-or-higher priority preempts and restarts). Otherwise ignored.
- On acceptance:
  - active_id ← winner; offset ← 0; mem_addr ← SFX_BASE[winner]; reps_left ← SFX_REP[winner].
  - prescaler ← 0; state ← PLAY.
  - duty is unchanged until the first tick.
- Tick: prescaler counts 0..RATE_DIV-1 and wraps. A tick occurs in the cycle where prescaler = RATE_DIV-1. The prescaler runs in all states.
- PLAY, on tick:
  - duty ← mem_data.
  - If offset < LAST: offset+1.
  - Else if reps_left > 0: offset ← LOOP, reps_left−1.
  - Else: state ← TAIL.
  - mem_addr ← BASE + new offset, modulo 2^ADDR_W.
- TAIL, on tick: duty ← 0, state ← IDLE, done ← 1 for one cycle. The last sample is therefore held for one full tick period.
- PWM:
  - pwm_cnt increments every cycle and wraps at 2^SAMPLE_W.
  - sound ← (pwm_cnt < (duty >> volume)).
  - duty = 0 gives a constant 0; sound is never continuously 1.
- A trigger accepted in the same cycle as a tick takes precedence: the tick action is discarded and no done pulse is issued.
- Preemption never produces done.

## Timing

- Reset values: state IDLE; sound 0, busy 0, done 0, active_id 0, mem_addr 0.
- Reset also zeroes duty, pwm_cnt, prescaler, offset and reps_left.
- rst mid-playback aborts immediately with no done pulse; rst overrides trigger.
- busy rises the cycle after an accepted trigger.
- The first sample reaches duty RATE_DIV cycles after acceptance. sound reflects a new duty one cycle later.
- Samples played for one effect: (LAST+1) + REP×(LAST−LOOP+1). Total busy duration: (samples+1)×RATE_DIV cycles.
- done coincides with the cycle in which busy falls.
- volume is sampled combinationally each cycle; a change takes effect on the next sound register update.

## Test plan

- RATE_DIV=4, effect 0: BASE=10, LAST=3, REP=0, ROM[a]=a.
  - Trigger bit 0 -> mem_addr 10,11,12,13; duty 10,11,12,13 on successive ticks.
  - done 20 cycles after acceptance; busy high 20 cycles.
- Loop, effect 1: LAST=5, LOOP=4, REP=2 -> offsets 0,1,2,3,4,5,4,5,4,5 (10 samples), then TAIL, done.
- Priority:
  - While effect 2 plays, trigger 3 -> ignored.
  - trigger 1 -> restart at effect 1 offset 0, active_id=1, no done for effect 2.
  - Simultaneous trigger=4'b0110 -> effect 1 wins.
- PWM: duty=64, SAMPLE_W=7, volume=0 -> sound high 64 of every 128 cycles; volume=2 -> 16 of 128.
- Reset mid-playback: assert rst during PLAY -> next cycle busy 0, sound 0, mem_addr 0, done never pulses.
- Trigger in the same cycle as a TAIL tick -> restart, busy stays high, done 0.
